// File: rtl/axi_wr_mst.sv
// AXI4 write-channel master: accepts one burst command, issues AW, streams W beats
// from the local data port, collects B and pulses done. One burst outstanding.
module axi_wr_mst #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                done,
    output logic [1:0]          done_resp,
    output logic                AW_VALID,
    input  logic                AW_READY,
    output logic [ADDR_W-1:0]   AW_ADDR,
    output logic [7:0]          AW_LEN,
    output logic [2:0]          AW_SIZE,
    output logic [1:0]          AW_BURST,
    output logic                W_VALID,
    input  logic                W_READY,
    output logic [DATA_W-1:0]   W_DATA,
    output logic [DATA_W/8-1:0] W_STRB,
    output logic                W_LAST,
    input  logic                B_VALID,
    output logic                B_READY,
    input  logic [1:0]          B_RESP,
    output logic [2:0]          dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic [2:0]  state;
    logic        run_q;
    logic [7:0]  cnt;
    logic        in_data;
    logic [16:0] span;
    logic [16:0] end_off;
    logic [6:0]  low_mask;
    logic        wrap_len_ok;
    logic        cmd_legal;

    // Command legality is judged on the raw command inputs in the accept cycle.
    always_comb begin
        span        = ({9'd0, cmd_len} + 17'd1) << cmd_size;
        end_off     = {5'd0, cmd_addr[11:0]} + span;
        low_mask    = 7'((8'd1 << cmd_size) - 8'd1);
        wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                      (cmd_len == 8'd7) || (cmd_len == 8'd15);
        cmd_legal   = 1'b1;
        if (cmd_size > 3'(MAX_SIZE)) cmd_legal = 1'b0;
        if (cmd_burst == 2'b11) cmd_legal = 1'b0;
        if (cmd_burst == 2'b10 && (!wrap_len_ok || (cmd_addr[6:0] & low_mask) != 7'd0))
            cmd_legal = 1'b0;
        if (cmd_burst == 2'b01 && end_off > 17'd4096) cmd_legal = 1'b0;
    end

    // Every channel transfers exactly on the edge where its VALID and READY are both
    // high; a VALID held by this block keeps its payload stable until that edge.
    // run_q keeps cmd_ready low while reset is asserted.
    assign in_data   = (state == S_DATA);
    assign cmd_ready = (state == S_IDLE) && run_q;
    assign AW_VALID  = (state == S_ADDR);
    assign W_VALID   = in_data && wd_valid;
    assign wd_ready  = in_data && W_READY;
    assign W_DATA    = in_data ? wd_data : '0;
    assign W_STRB    = in_data ? wd_strb : '0;
    assign W_LAST    = W_VALID && (cnt == AW_LEN);
    assign B_READY   = (state == S_RESP);
    assign dbg_state = state;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= S_IDLE;
            run_q     <= 1'b0;
            cnt       <= 8'd0;
            AW_ADDR   <= '0;
            AW_LEN    <= 8'd0;
            AW_SIZE   <= 3'd0;
            AW_BURST  <= 2'd0;
            done      <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            run_q <= 1'b1;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        AW_ADDR  <= cmd_addr;
                        AW_LEN   <= cmd_len;
                        AW_SIZE  <= cmd_size;
                        AW_BURST <= cmd_burst;
                        cnt      <= 8'd0;
                        state    <= cmd_legal ? S_ADDR : S_ERR;
                    end
                end
                S_ADDR: begin
                    if (AW_READY) state <= S_DATA;
                end
                S_DATA: begin
                    if (W_VALID && W_READY) begin
                        if (cnt == AW_LEN) begin
                            cnt   <= 8'd0;
                            state <= S_RESP;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (B_VALID) begin
                        done      <= 1'b1;
                        done_resp <= B_RESP;
                        state     <= S_IDLE;
                    end
                end
                S_ERR: begin
                    // Refused locally: report SLVERR without touching the bus.
                    done      <= 1'b1;
                    done_resp <= 2'b10;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_mst.sv
// Bench for axi_wr_mst: scenario tasks drive a cycle-level slave/source and compare
// against a legality model and a data scoreboard.
module tb_axi_wr_mst;
    localparam int W = 36;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        done;
    logic [1:0]  done_resp;
    logic        AW_VALID, AW_READY;
    logic [31:0] AW_ADDR;
    logic [7:0]  AW_LEN;
    logic [2:0]  AW_SIZE;
    logic [1:0]  AW_BURST;
    logic        W_VALID, W_READY, W_LAST;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        B_VALID, B_READY;
    logic [1:0]  B_RESP;
    logic [2:0]  dbg_state;
    logic [89:0] all_outs;

    axi_wr_mst #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .done(done), .done_resp(done_resp),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
        .AW_SIZE(AW_SIZE), .AW_BURST(AW_BURST),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
        .W_LAST(W_LAST), .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
        .dbg_state(dbg_state)
    );

    assign all_outs = {cmd_ready, wd_ready, done, done_resp, AW_VALID, AW_ADDR, AW_LEN,
                       AW_SIZE, AW_BURST, W_VALID, W_DATA, W_STRB, W_LAST, B_READY};

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    bit          r_timeout, r_aw_seen, r_aw_done, r_aw_unstable, r_w_before_aw;
    bit          r_b_early_taken, r_rdy_at_done, r_done_next;
    int          r_beats, r_last_bad, r_done_lat, r_acc_wait;
    logic [1:0]  r_done_resp, r_resp_next;
    logic [31:0] r_aw_addr;
    logic [7:0]  r_aw_len;
    logic [2:0]  r_aw_size;
    logic [1:0]  r_aw_burst;

    // Reference legality rules for a 4-byte data bus.
    function automatic bit model_legal(logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                                       logic [1:0] burst);
        int bytes;
        int span;
        bytes = 1 << size;
        span  = (int'(len) + 1) * bytes;
        if (size > 3'd2) return 1'b0;
        if (burst == 2'b11) return 1'b0;
        if (burst == 2'b10) begin
            if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) return 1'b0;
            if (int'(addr & 32'h7F) % bytes != 0) return 1'b0;
        end
        if (burst == 2'b01 && int'(addr & 32'hFFF) + span > 4096) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0;
        AW_READY = 0; W_READY = 0; B_VALID = 0; B_RESP = 0;
    endtask

    // Offers one command, then plays slave and data source cycle by cycle, recording
    // what it observes; each scenario judges the recordings.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int aw_stall, input int w_mode, input int gap_pct,
                             input logic [1:0] bresp, input bit early_b);
        logic [W-1:0] src[$];
        int n, idx, guard;
        bit wd_hs, last_w_done, b_taken;
        r_timeout = 0; r_aw_seen = 0; r_aw_done = 0; r_aw_unstable = 0; r_w_before_aw = 0;
        r_b_early_taken = 0; r_rdy_at_done = 0; r_done_next = 0; r_beats = 0;
        r_last_bad = 0; r_done_lat = -1; r_done_resp = 0; r_resp_next = 0;
        r_aw_addr = 0; r_aw_len = 0; r_aw_size = 0; r_aw_burst = 0;
        got_q.delete();
        exp_q.delete();
        n = int'(len) + 1;
        for (int i = 0; i < n; i++) src.push_back({4'($urandom_range(0, 15)), 32'($urandom)});
        exp_q = src;
        @(negedge ACLK);
        cmd_valid = 1; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
        #1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge ACLK);
            #1;
            guard++;
        end
        r_acc_wait = guard;
        if (!cmd_ready) begin
            r_timeout = 1;
            cmd_valid = 0;
            return;
        end
        idx = 0; wd_hs = 0; b_taken = 0;
        for (int k = 1; k <= 400 && r_done_lat < 0; k++) begin
            @(negedge ACLK);
            cmd_valid = 0;
            if (wd_hs) begin
                idx++;
                wd_valid = 0;
            end
            if (!wd_valid && idx < n && $urandom_range(0, 99) >= gap_pct) begin
                wd_valid = 1;
                {wd_strb, wd_data} = src[idx];
            end
            AW_READY = (k > aw_stall);
            case (w_mode)
                0: W_READY = 1'b1;
                1: W_READY = (k % 2 == 1);
                default: W_READY = 1'($urandom_range(0, 1));
            endcase
            last_w_done = (r_beats >= n);
            B_VALID = (early_b && !last_w_done) || (last_w_done && !b_taken);
            B_RESP  = last_w_done ? bresp : 2'b11;
            #1;
            if (W_VALID && !r_aw_done) r_w_before_aw = 1;
            if (AW_VALID) begin
                if (!r_aw_seen) {r_aw_addr, r_aw_len, r_aw_size, r_aw_burst} =
                                {AW_ADDR, AW_LEN, AW_SIZE, AW_BURST};
                else if ({AW_ADDR, AW_LEN, AW_SIZE, AW_BURST} !==
                         {r_aw_addr, r_aw_len, r_aw_size, r_aw_burst}) r_aw_unstable = 1;
                r_aw_seen = 1;
                if (AW_READY) r_aw_done = 1;
            end
            if (B_VALID && B_READY && !last_w_done) r_b_early_taken = 1;
            if (B_VALID && B_READY && last_w_done) b_taken = 1;
            wd_hs = wd_valid && wd_ready;
            if (W_VALID && W_READY) begin
                got_q.push_back({W_STRB, W_DATA});
                if (W_LAST !== (r_beats == n - 1)) r_last_bad++;
                r_beats++;
            end
            if (done === 1'b1) begin
                r_done_lat    = k;
                r_done_resp   = done_resp;
                r_rdy_at_done = cmd_ready;
            end
        end
        AW_READY = 0; W_READY = 0; wd_valid = 0; B_VALID = 0; B_RESP = 0;
        if (r_done_lat < 0) begin
            r_timeout = 1;
        end else begin
            @(negedge ACLK);
            #1;
            r_done_next = done;
            r_resp_next = done_resp;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESETn = 0;
        cmd_valid = 1; wd_valid = 1; AW_READY = 1; W_READY = 1; B_VALID = 1; B_RESP = 2'b10;
        repeat (3) @(posedge ACLK);
        #1;
        total++; if (all_outs !== '0) begin bad++; $display("FAIL reset_outs got=%h want=0", all_outs); end
        @(negedge ACLK);
        idle_inputs();
        ARESETn = 1;
        @(posedge ACLK);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_incr_basic();
        logic [W-1:0] g, e;
        run_burst(32'h100, 8'd3, 3'd2, 2'b01, 0, 0, 0, 2'b00, 1'b0);
        total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL incr_timeout got=%b want=0", r_timeout); end
        total++; if (r_aw_addr !== 32'h100) begin bad++; $display("FAIL incr_aw_addr got=%h want=100", r_aw_addr); end
        total++; if (r_aw_len !== 8'd3) begin bad++; $display("FAIL incr_aw_len got=%0d want=3", r_aw_len); end
        total++; if ({r_aw_size, r_aw_burst} !== {3'd2, 2'b01}) begin bad++; $display("FAIL incr_aw_size_burst got=%b want=01001", {r_aw_size, r_aw_burst}); end
        total++; if (r_last_bad !== 0) begin bad++; $display("FAIL incr_wlast got=%0d want=0 misplaced", r_last_bad); end
        total++; if (r_done_lat !== 7) begin bad++; $display("FAIL incr_latency got=%0d want=7", r_done_lat); end
        total++; if (r_done_resp !== 2'b00) begin bad++; $display("FAIL incr_resp got=%b want=00", r_done_resp); end
        total++; if (r_rdy_at_done !== 1'b1) begin bad++; $display("FAIL incr_ready_at_done got=%b want=1", r_rdy_at_done); end
        total++; if (r_done_next !== 1'b0) begin bad++; $display("FAIL incr_done_pulse got=%b want=0", r_done_next); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL incr_beats got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL incr_data got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        run_burst(32'h40, 8'd0, 3'd2, 2'b01, 0, 0, 0, 2'b01, 1'b0);
        total++; if (r_done_lat !== 4) begin bad++; $display("FAIL b2b_min_latency got=%0d want=4", r_done_lat); end
        total++; if (r_done_resp !== 2'b01) begin bad++; $display("FAIL b2b_resp got=%b want=01", r_done_resp); end
        run_burst(32'h80, 8'd1, 3'd1, 2'b01, 0, 0, 0, 2'b00, 1'b0);
        total++; if (r_acc_wait !== 0) begin bad++; $display("FAIL b2b_accept_wait got=%0d want=0", r_acc_wait); end
        total++; if (r_done_lat !== 5) begin bad++; $display("FAIL b2b_latency got=%0d want=5", r_done_lat); end
    endtask

    task automatic test_aw_stall();
        run_burst(32'h100, 8'd3, 3'd2, 2'b01, 5, 0, 0, 2'b00, 1'b0);
        total++; if (r_aw_seen !== 1'b1) begin bad++; $display("FAIL stall_aw_seen got=%b want=1", r_aw_seen); end
        total++; if (r_aw_unstable !== 1'b0) begin bad++; $display("FAIL stall_aw_stable got=%b want=0", r_aw_unstable); end
        total++; if (r_aw_addr !== 32'h100) begin bad++; $display("FAIL stall_aw_addr got=%h want=100", r_aw_addr); end
        total++; if (r_w_before_aw !== 1'b0) begin bad++; $display("FAIL stall_w_early got=%b want=0", r_w_before_aw); end
        total++; if (r_done_lat !== 12) begin bad++; $display("FAIL stall_latency got=%0d want=12", r_done_lat); end
    endtask

    task automatic test_w_throttle();
        logic [W-1:0] g, e;
        run_burst(32'h180, 8'd7, 3'd2, 2'b01, 0, 1, 40, 2'b00, 1'b0);
        total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL thr_timeout got=%b want=0", r_timeout); end
        total++; if (r_beats !== 8) begin bad++; $display("FAIL thr_beats got=%0d want=8", r_beats); end
        total++; if (r_last_bad !== 0) begin bad++; $display("FAIL thr_wlast got=%0d want=0 misplaced", r_last_bad); end
        total++; if (r_done_resp !== 2'b00) begin bad++; $display("FAIL thr_resp got=%b want=00", r_done_resp); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL thr_data got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_bresp_err();
        run_burst(32'h400, 8'd3, 3'd2, 2'b01, 0, 0, 0, 2'b10, 1'b1);
        total++; if (r_b_early_taken !== 1'b0) begin bad++; $display("FAIL berr_early_taken got=%b want=0", r_b_early_taken); end
        total++; if (r_beats !== 4) begin bad++; $display("FAIL berr_beats got=%0d want=4", r_beats); end
        total++; if (r_done_resp !== 2'b10) begin bad++; $display("FAIL berr_resp got=%b want=10", r_done_resp); end
        total++; if (r_resp_next !== 2'b10) begin bad++; $display("FAIL berr_resp_hold got=%b want=10", r_resp_next); end
    endtask

    task automatic test_illegal();
        logic [31:0] a[5];
        logic [7:0]  l[5];
        logic [2:0]  s[5];
        logic [1:0]  b[5];
        a[0] = 32'h100; l[0] = 8'd2; s[0] = 3'd2; b[0] = 2'b10;
        a[1] = 32'hFF8; l[1] = 8'd3; s[1] = 3'd2; b[1] = 2'b01;
        a[2] = 32'h000; l[2] = 8'd0; s[2] = 3'd3; b[2] = 2'b01;
        a[3] = 32'h000; l[3] = 8'd0; s[3] = 3'd0; b[3] = 2'b11;
        a[4] = 32'h102; l[4] = 8'd3; s[4] = 3'd2; b[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            run_burst(a[i], l[i], s[i], b[i], 0, 0, 0, 2'b00, 1'b0);
            total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL ill%0d_timeout got=%b want=0", i, r_timeout); end
            total++; if (r_aw_seen !== 1'b0) begin bad++; $display("FAIL ill%0d_aw got=%b want=0", i, r_aw_seen); end
            total++; if (r_beats !== 0) begin bad++; $display("FAIL ill%0d_beats got=%0d want=0", i, r_beats); end
            total++; if (r_done_resp !== 2'b10) begin bad++; $display("FAIL ill%0d_resp got=%b want=10", i, r_done_resp); end
            total++; if (r_done_next !== 1'b0) begin bad++; $display("FAIL ill%0d_pulse got=%b want=0", i, r_done_next); end
        end
        // Ends exactly on the 4KB boundary, so it must go out on the bus.
        run_burst(32'hFF0, 8'd3, 3'd2, 2'b01, 0, 0, 0, 2'b00, 1'b0);
        total++; if (r_aw_seen !== 1'b1) begin bad++; $display("FAIL edge4k_aw got=%b want=1", r_aw_seen); end
        total++; if (r_done_resp !== 2'b00) begin bad++; $display("FAIL edge4k_resp got=%b want=00", r_done_resp); end
    endtask

    task automatic test_reset_mid();
        int beats;
        bit hit, done_seen;
        @(negedge ACLK);
        cmd_valid = 1; cmd_addr = 32'h200; cmd_len = 8'd7; cmd_size = 3'd2; cmd_burst = 2'b01;
        AW_READY = 1; W_READY = 1; B_VALID = 0; wd_valid = 1; wd_strb = 4'hF;
        beats = 0; hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge ACLK);
            cmd_valid = 0;
            wd_data = $urandom;
            #1;
            if (beats == 2 && W_VALID) begin
                ARESETn = 0;
                hit = 1;
            end else if (W_VALID && W_READY) begin
                beats++;
            end
        end
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL rstmid_reach_beat2 got=%0d beats want=2", beats); end
        @(posedge ACLK);
        #1;
        total++; if (all_outs !== '0) begin bad++; $display("FAIL rstmid_outs got=%h want=0", all_outs); end
        @(negedge ACLK);
        idle_inputs();
        ARESETn = 1;
        done_seen = 0;
        repeat (10) begin
            @(negedge ACLK);
            #1;
            if (done === 1'b1) done_seen = 1;
        end
        total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done got=%b want=0", done_seen); end
        run_burst(32'h300, 8'd1, 3'd2, 2'b01, 0, 0, 0, 2'b00, 1'b0);
        total++; if (r_beats !== 2) begin bad++; $display("FAIL rstmid_next_beats got=%0d want=2", r_beats); end
        total++; if (r_done_lat !== 5) begin bad++; $display("FAIL rstmid_next_latency got=%0d want=5", r_done_lat); end
        total++; if (r_done_resp !== 2'b00) begin bad++; $display("FAIL rstmid_next_resp got=%b want=00", r_done_resp); end
    endtask

    task automatic test_random();
        logic [7:0]  lens[8];
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst, bresp;
        logic [W-1:0] g, e;
        bit legal;
        lens = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15, 8'd4, 8'd20};
        for (int it = 0; it < 30; it++) begin
            addr  = $urandom;
            if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hFC0 | 12'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) addr[2:0] = 3'd0;
            len   = lens[$urandom_range(0, 7)];
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 3));
            bresp = 2'($urandom_range(0, 3));
            legal = model_legal(addr, len, size, burst);
            run_burst(addr, len, size, burst, $urandom_range(0, 3), 2, $urandom_range(0, 50), bresp, 1'b0);
            total++; if (r_timeout !== 1'b0) begin bad++; $display("FAIL rnd%0d_timeout got=%b want=0", it, r_timeout); end
            total++; if (r_aw_seen !== legal) begin bad++; $display("FAIL rnd%0d_aw_seen got=%b want=%b a=%h l=%0d s=%0d b=%0d", it, r_aw_seen, legal, addr, len, size, burst); end
            if (legal) begin
                total++; if ({r_aw_addr, r_aw_len, r_aw_size, r_aw_burst} !== {addr, len, size, burst}) begin bad++; $display("FAIL rnd%0d_aw got=%h want=%h", it, {r_aw_addr, r_aw_len, r_aw_size, r_aw_burst}, {addr, len, size, burst}); end
                total++; if (r_done_resp !== bresp) begin bad++; $display("FAIL rnd%0d_resp got=%b want=%b", it, r_done_resp, bresp); end
                total++; if (r_last_bad !== 0) begin bad++; $display("FAIL rnd%0d_wlast got=%0d want=0 misplaced", it, r_last_bad); end
                total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_beats got=%0d want=%0d", it, got_q.size(), exp_q.size()); end
                while (got_q.size() > 0 && exp_q.size() > 0) begin
                    g = got_q.pop_front();
                    e = exp_q.pop_front();
                    total++; if (g !== e) begin bad++; $display("FAIL rnd%0d_data got=%h want=%h", it, g, e); end
                end
            end else begin
                total++; if (r_done_resp !== 2'b10) begin bad++; $display("FAIL rnd%0d_ill_resp got=%b want=10", it, r_done_resp); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        ARESETn = 0;
        test_reset();
        test_incr_basic();
        test_back_to_back();
        test_aw_stall();
        test_w_throttle();
        test_bresp_err();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
